// File: rtl/sqrt_job_scheduler.sv
// Two-requester round-robin front end for a fixed-latency SquareRoot core:
// latches the winner's operands, pulses Start, waits CORE_LAT cycles, returns O.
module sqrt_job_scheduler #(
  parameter int W        = 16,
  parameter int CORE_LAT = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req0,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  output logic         Gnt0,
  output logic         Done0,
  output logic [W-1:0] O0,
  input  logic         Req1,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  output logic         Gnt1,
  output logic         Done1,
  output logic [W-1:0] O1,
  output logic         CoreStart,
  output logic [W-1:0] CoreA,
  output logic [W-1:0] CoreB,
  input  logic [W-1:0] CoreO,
  output logic         Busy
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, DONE} state_e;

  localparam logic [7:0] LAT = 8'(CORE_LAT);

  state_e       state_q, state_d;
  logic         win_q, win_d;
  logic         last_q, last_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic         done0_q, done0_d, done1_q, done1_d;
  logic         start_q, start_d;
  logic         busy_q, busy_d;
  logic [W-1:0] o0_q, o0_d, o1_q, o1_d;
  logic [W-1:0] core_a_q, core_a_d, core_b_q, core_b_d;

  // Pulses are computed one state early so they appear registered in the
  // state they belong to (Gnt/Start in LAUNCH, Done in DONE).
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    o0_d     = o0_q;
    o1_d     = o1_q;
    core_a_d = core_a_q;
    core_b_d = core_b_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          win_d    = (Req0 && Req1) ? ~last_q : Req1;
          last_d   = win_d;
          core_a_d = win_d ? A1 : A0;
          core_b_d = win_d ? B1 : B0;
          gnt0_d   = ~win_d;
          gnt1_d   = win_d;
          start_d  = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (win_q) o1_d = CoreO;
        else       o0_d = CoreO;
        done0_d = ~win_q;
        done1_d = win_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      o0_q     <= '0;
      o1_q     <= '0;
      core_a_q <= '0;
      core_b_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      o0_q     <= o0_d;
      o1_q     <= o1_d;
      core_a_q <= core_a_d;
      core_b_q <= core_b_d;
    end
  end

  assign Gnt0      = gnt0_q;
  assign Gnt1      = gnt1_q;
  assign Done0     = done0_q;
  assign Done1     = done1_q;
  assign O0        = o0_q;
  assign O1        = o1_q;
  assign CoreStart = start_q;
  assign CoreA     = core_a_q;
  assign CoreB     = core_b_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_sqrt_job_scheduler.sv
// Bench for sqrt_job_scheduler: vector table, directed corner sequences and a
// randomized run against a job-level reference model; two DUTs (CORE_LAT 8 and 1).
module tb_sqrt_job_scheduler;
  localparam int L = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic gnt0, gnt1, done0, done1, cs, busy;
  logic [15:0] o0, o1, ca, cb, co;

  logic req0_s, req1_s;
  logic [15:0] a0_s, b0_s, a1_s, b1_s;
  logic gnt0_s, gnt1_s, done0_s, done1_s, cs_s, busy_s;
  logic [15:0] o0_s, o1_s, ca_s, cb_s, co_s;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  // Core model: hypotenuse of the operands, valid only from CORE_LAT cycles
  // after the Start cycle; junk before that.
  function automatic logic [15:0] hyp(input logic [15:0] x, input logic [15:0] y);
    longint unsigned s, r, t;
    s = longint'(x) * longint'(x) + longint'(y) * longint'(y);
    r = 0;
    for (int i = 17; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= s) r = t;
    end
    return r[15:0];
  endfunction

  logic [7:0]  age = 8'hff;
  logic [15:0] core_res = '0;
  always @(posedge clk) begin
    if (cs) begin
      age      <= 8'd0;
      core_res <= hyp(ca, cb);
    end else if (age != 8'hff) begin
      age <= age + 8'd1;
    end
  end
  assign co   = (age != 8'hff && int'(age) >= L - 1) ? core_res : 16'hBEEF;
  assign co_s = hyp(ca_s, cb_s);

  sqrt_job_scheduler #(.W(16), .CORE_LAT(L)) dut (
    .Clk(clk), .Reset(rst),
    .Req0(req0), .A0(a0), .B0(b0), .Gnt0(gnt0), .Done0(done0), .O0(o0),
    .Req1(req1), .A1(a1), .B1(b1), .Gnt1(gnt1), .Done1(done1), .O1(o1),
    .CoreStart(cs), .CoreA(ca), .CoreB(cb), .CoreO(co), .Busy(busy)
  );

  sqrt_job_scheduler #(.W(16), .CORE_LAT(1)) dut_s (
    .Clk(clk), .Reset(rst),
    .Req0(req0_s), .A0(a0_s), .B0(b0_s), .Gnt0(gnt0_s), .Done0(done0_s), .O0(o0_s),
    .Req1(req1_s), .A1(a1_s), .B1(b1_s), .Gnt1(gnt1_s), .Done1(done1_s), .O1(o1_s),
    .CoreStart(cs_s), .CoreA(ca_s), .CoreB(cb_s), .CoreO(co_s), .Busy(busy_s)
  );

  typedef struct {
    logic        r0, r1;
    logic [15:0] a0, b0, a1, b1;
    logic        w;
    logic [15:0] o;
  } vec_t;

  vec_t tbl[8];
  logic [15:0] eo0, eo1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; req0_s = 0; req1_s = 0;
    rst = 1;
    step();
    chk("rst_pulses", {gnt0, gnt1, done0, done1, cs, busy}, 0);
    chk("rst_o0", o0, 0);
    chk("rst_o1", o1, 0);
    chk("rst_core_a", ca, 0);
    chk("rst_core_b", cb, 0);
    chk("rst_s_state", {gnt0_s, gnt1_s, done0_s, done1_s, cs_s, busy_s, o0_s, o1_s}, 0);
    rst = 0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] wa, wb;
    wa = v.w ? v.a1 : v.a0;
    wb = v.w ? v.b1 : v.b0;
    req0 = v.r0; req1 = v.r1; a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    step();
    chk("tbl_gnt0", gnt0, !v.w);
    chk("tbl_gnt1", gnt1, v.w);
    chk("tbl_start", cs, 1);
    chk("tbl_core_a", ca, wa);
    chk("tbl_core_b", cb, wb);
    chk("tbl_busy_t1", busy, 1);
    req0 = 0; req1 = 0;
    for (int k = 2; k <= L + 2; k++) begin
      step();
      chk("tbl_quiet", {gnt0, gnt1, cs, done0, done1}, 0);
      chk("tbl_busy", busy, 1);
    end
    step();
    if (v.w) eo1 = v.o;
    else     eo0 = v.o;
    chk("tbl_done0", done0, !v.w);
    chk("tbl_done1", done1, v.w);
    chk("tbl_o0", o0, eo0);
    chk("tbl_o1", o1, eo1);
    step();
    chk("tbl_idle_busy", busy, 0);
    chk("tbl_idle_done", {done0, done1}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 0,    3,  4,  0,  0, 0,     5};
    tbl[1] = '{1, 1,   12,  5,  8, 15, 1,    17};
    tbl[2] = '{1, 1,   12,  5,  8, 15, 0,    13};
    tbl[3] = '{0, 1,    0,  0,  0,  0, 1,     0};
    tbl[4] = '{0, 1,    0,  0,  6,  8, 1,    10};
    tbl[5] = '{1, 1,   20, 21,  9, 40, 0,    29};
    tbl[6] = '{1, 1,    5, 12,  7, 24, 1,    25};
    tbl[7] = '{1, 0, 65535, 0,  0,  0, 0, 65535};

    rst = 1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    req0_s = 0; req1_s = 0; a0_s = 0; b0_s = 0; a1_s = 0; b1_s = 0;
    step();
    do_reset();

    eo0 = 0; eo1 = 0;
    foreach (tbl[i]) run_vec(tbl[i]);

    // Fairness: both requesters held for four jobs, grants every L+4 cycles.
    do_reset();
    req0 = 1; req1 = 1; a0 = 3; b0 = 4; a1 = 8; b1 = 15;
    for (int i = 1; i <= 4 * (L + 4); i++) begin
      int k;
      logic eg0, eg1;
      step();
      k = i - 1;
      eg0 = (k % (L + 4) == 0) && (k / (L + 4) < 4) && ((k / (L + 4)) % 2 == 0);
      eg1 = (k % (L + 4) == 0) && (k / (L + 4) < 4) && ((k / (L + 4)) % 2 == 1);
      chk("fair_gnt0", gnt0, eg0);
      chk("fair_gnt1", gnt1, eg1);
      if (k == 3 * (L + 4)) begin req0 = 0; req1 = 0; end
    end
    chk("fair_o0", o0, 5);
    chk("fair_o1", o1, 17);

    // Operand isolation: A0 changes right after the grant.
    do_reset();
    req0 = 1; a0 = 3; b0 = 4;
    step();
    chk("iso_gnt0", gnt0, 1);
    req0 = 0; a0 = 100;
    for (int k = 2; k <= L + 2; k++) begin
      step();
      chk("iso_core_a", ca, 3);
    end
    step();
    chk("iso_done0", done0, 1);
    chk("iso_o0", o0, 5);
    chk("iso_o1", o1, 0);
    chk("iso_core_a_done", ca, 3);

    // Reset in the middle of a requester-1 job, then a fresh requester-0 job.
    do_reset();
    req1 = 1; a1 = 6; b1 = 8;
    step();
    chk("mid_gnt1", gnt1, 1);
    req1 = 0;
    for (int k = 2; k <= 5; k++) step();
    do_reset();
    req0 = 1; a0 = 5; b0 = 12;
    step();
    chk("mid_gnt0", gnt0, 1);
    chk("mid_core_a", ca, 5);
    req0 = 0;
    for (int k = 2; k <= L + 3; k++) begin
      step();
      chk("mid_no_done1", done1, 0);
      if (k == L + 3) begin
        chk("mid_done0", done0, 1);
        chk("mid_o0", o0, 13);
        chk("mid_o1", o1, 0);
      end
    end

    // CORE_LAT = 1 on the second instance.
    for (int j = 0; j < 2; j++) begin
      logic [15:0] ea, eb;
      ea = (j == 0) ? 16'd0 : 16'd6;
      eb = (j == 0) ? 16'd0 : 16'd8;
      req1_s = 1; a1_s = ea; b1_s = eb;
      step();
      chk("lat1_gnt1", gnt1_s, 1);
      chk("lat1_start", cs_s, 1);
      req1_s = 0;
      step();
      chk("lat1_t2", {busy_s, done0_s, done1_s}, 3'b100);
      step();
      chk("lat1_t3", {busy_s, done0_s, done1_s}, 3'b100);
      step();
      chk("lat1_done1", done1_s, 1);
      chk("lat1_o1", o1_s, (j == 0) ? 32'd0 : 32'd10);
      chk("lat1_o0", o0_s, 0);
      step();
      chk("lat1_idle", {busy_s, done1_s}, 0);
    end

    // Randomized traffic against a job-level timing model.
    do_reset();
    begin
      logic        pend[2];
      logic [15:0] ra[2], rb[2];
      logic [15:0] mo[2];
      logic [15:0] eca, ecb, ja, jb, jres;
      logic        job_on, jw, last, g, d;
      int          jt0;
      pend[0] = 0; pend[1] = 0; ra[0] = 0; ra[1] = 0; rb[0] = 0; rb[1] = 0;
      mo[0] = 0; mo[1] = 0; eca = 0; ecb = 0; job_on = 0; last = 1;
      jw = 0; jt0 = 0; ja = 0; jb = 0; jres = 0;
      for (int n = 0; n < 700; n++) begin
        if (n > 0) step();
        if (job_on && cyc == jt0 + 1) begin eca = ja; ecb = jb; end
        if (job_on && cyc == jt0 + L + 3) mo[jw] = jres;
        if (job_on && cyc == jt0 + L + 4) job_on = 0;
        g = job_on && (cyc == jt0 + 1);
        d = job_on && (cyc == jt0 + L + 3);
        chk("rnd_gnt0", gnt0, g && !jw);
        chk("rnd_gnt1", gnt1, g && jw);
        chk("rnd_start", cs, g);
        chk("rnd_done0", done0, d && !jw);
        chk("rnd_done1", done1, d && jw);
        chk("rnd_busy", busy, job_on);
        chk("rnd_o0", o0, mo[0]);
        chk("rnd_o1", o1, mo[1]);
        chk("rnd_core_a", ca, eca);
        chk("rnd_core_b", cb, ecb);
        if (g) pend[jw] = 0;
        for (int r = 0; r < 2; r++) begin
          if (!pend[r]) begin
            if ($urandom_range(0, 3) == 0) begin
              pend[r] = 1;
              ra[r] = 16'($urandom_range(0, 65535));
              rb[r] = 16'($urandom_range(0, 65535));
            end
          end else if ($urandom_range(0, 15) == 0) begin
            pend[r] = 0;
          end
        end
        req0 = pend[0]; a0 = ra[0]; b0 = rb[0];
        req1 = pend[1]; a1 = ra[1]; b1 = rb[1];
        if (!job_on && (pend[0] || pend[1])) begin
          jw = (pend[0] && pend[1]) ? !last : pend[1];
          last = jw;
          ja = ra[jw]; jb = rb[jw];
          jres = hyp(ja, jb);
          jt0 = cyc;
          job_on = 1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sqrt_job_scheduler.md
Name: sqrt_job_scheduler

Overview:
- Shares one SquareRoot core (16-bit A/B operands in, 16-bit O out, Start/Reset/Clk) between two independent requesters.
- Round-robin arbitration; latches the winner's operands and pulses the core's Start.
- Waits a fixed, parameterised core latency, then captures O and returns it to the winning requester with a one-cycle done pulse.
- Sits between the requesting subsystems and the SquareRoot top.

Parameters:
- W, 16, operand/result width; matches core A, B, O.
- CORE_LAT, 8, clock cycles from the Start cycle until core O is valid and stable; legal range 1..255.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req0  input  1  requester 0 job request; hold high with A0/B0 stable until Gnt0.
- A0  input  W  requester 0 operand A.
- B0  input  W  requester 0 operand B.
- Gnt0  output  1  one-cycle pulse; A0/B0 have been latched.
- Done0  output  1  one-cycle pulse; O0 holds requester 0 result.
- O0  output  W  requester 0 result register; holds until its next capture.
- Req1, A1, B1, Gnt1, Done1, O1  same as above, for requester 1.
- CoreStart  output  1  drives core Start; one-cycle pulse per job.
- CoreA  output  W  latched operand A to core; stable for the whole job.
- CoreB  output  W  latched operand B to core; stable for the whole job.
- CoreO  input  W  core result.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset is synchronous, active-high. In the cycle after Reset is sampled high:
  - state = IDLE.
  - Gnt0, Gnt1, Done0, Done1, CoreStart, Busy = 0.
  - O0, O1, CoreA, CoreB = 0.
  - Last-served pointer = 1, so requester 0 wins the first tie.
  - Wait counter = 0.
- Reset mid-job: the job is abandoned; no Done is issued; no result register changes.
- State machine, registered outputs (t0 = IDLE cycle in which a request is sampled):
  - IDLE (t0): sample Req0/Req1. If either is high, pick the winner, latch its A/B into CoreA/CoreB, record the winner, set Last = winner, go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH (t1): CoreStart = 1, GntX = 1 for the winner. Load wait counter with CORE_LAT. Go to WAIT.
  - WAIT (t2 .. t1+CORE_LAT): decrement the counter each cycle; exactly CORE_LAT cycles. Go to CAPTURE.
  - CAPTURE (t2+CORE_LAT): register CoreO into the winner's OX at the end of the cycle. The other OX is unchanged. Go to DONE.
  - DONE (t3+CORE_LAT): DoneX = 1 for the winner; OX already valid. Go to IDLE.
- Latency: request sampled at t0 → Gnt at t0+1 → Done at t0+CORE_LAT+3. Next arbitration no earlier than t0+CORE_LAT+4. Throughput is one job per CORE_LAT+4 cycles.
- Arbitration: if only one Req is high, that requester wins. If both are high, the requester not equal to Last wins. Requests are evaluated only in IDLE.
- Requester handshake:
  - A Req still high in the cycle after Gnt counts as a new request.
  - A Req that drops before its grant is silently ignored.
  - A/B changes after Gnt have no effect on CoreA/CoreB.
- Never more than one Gnt, Done or CoreStart high in any cycle. CoreStart and Gnt are always coincident.
- CoreA/CoreB hold their values after a job until the next grant.
- No arithmetic is performed on the result; O is passed through from CoreO at full W width, unmodified.

Test Plan:
- Single job: after reset, Req0=1, A0=3, B0=4 sampled at t0. Core model returns 5 at CORE_LAT=8 → Gnt0 and CoreStart at t1, CoreA=3, CoreB=4, Done0 at t11, O0=5, O1 stays 0, Busy high t1..t11.
- Simultaneous requests after reset: Req0 (A0=12, B0=5) and Req1 (A1=8, B1=15) both held at t0 → Gnt0 at t1, Done0 at t11 with O0=13. Then Gnt1 at t13, Done1 at t23 with O1=17.
- Fairness: Req0 and Req1 held high continuously for 4 jobs → grant order 0,1,0,1 with spacing 12 cycles. Never two Gnt in one cycle.
- Operand isolation: change A0 from 3 to 100 the cycle after Gnt0 → CoreA stays 3 through Done0, O0=5.
- Reset mid-job: assert Reset at t5 of a Req1 job → all outputs 0 the next cycle, no Done1. A fresh Req0 then completes normally, with Gnt0 at one cycle after the request is sampled.
- Boundary CORE_LAT=1: Req1 (A1=0, B1=0) at t0 → Gnt1 at t1, Done1 at t4, O1=0, back in IDLE at t5.
